// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for the shared RAM: serialises CPU and loader
// accesses, drives the RAM command bus and returns read data with a completion pulse.
module mem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [1:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic            sel;
  logic [1:0]      cmd_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [2:0]      cnt, cnt_nx;
  logic            last_gnt;
  logic [DW-1:0]   rdata_q;
  logic            take;
  logic            pick;
  logic            capture;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    pick     = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          take = 1'b1;
          // On a tie the loser of the previous grant wins unless the CPU has fixed priority
          if (req0 && req1) pick = (CPU_PRIO != 0) ? 1'b0 : ~last_gnt;
          else              pick = req1;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cmd_q == MREAD) begin
          state_nx = S_WAIT;
          cnt_nx   = WAIT_INIT;
        end else begin
          state_nx = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = S_RESP;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      sel      <= 1'b0;
      cmd_q    <= MNONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      last_gnt <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take) begin
        sel     <= pick;
        cmd_q   <= pick ? cmd1   : cmd0;
        addr_q  <= pick ? addr1  : addr0;
        wdata_q <= pick ? wdata1 : wdata0;
      end
      if (capture) rdata_q <= mem_rdata;
      if (state == S_RESP) last_gnt <= sel;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_cmd   = MNONE;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_ACCESS: begin
        gnt0 = ~sel;
        gnt1 = sel;
        // Unused command codes complete as no-ops without touching the RAM
        if (cmd_q == MREAD || cmd_q == MWRITE) begin
          mem_cmd  = cmd_q;
          mem_addr = addr_q;
        end
        if (cmd_q == MWRITE) mem_wdata = wdata_q;
      end
      S_WAIT: begin
        mem_cmd  = MREAD;
        mem_addr = addr_q;
      end
      S_RESP: begin
        done0 = ~sel;
        done1 = sel;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one round-robin RD_LAT=1 instance and one
// CPU-priority RD_LAT=3 instance, each behind a behavioural RAM with read latency.
module tb_mem_arbiter;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk;
  logic [1:0] rst, req0, req1, gnt0, gnt1, done0, done1, busy;
  logic [1:0][1:0]  cmd0, cmd1, mem_cmd;
  logic [1:0][7:0]  addr0, addr1, mem_addr;
  logic [1:0][15:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;

  logic [15:0] ram    [2][256];
  logic [15:0] shadow [2][256];
  logic [15:0] pipe   [2][3];
  logic [15:0] exp_last [2];
  exp_t sb [4][$];
  int   gseq [2][$];
  int   gcyc [4];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  mem_arbiter #(.AW(8), .DW(16), .RD_LAT(RL0), .CPU_PRIO(0)) u_rr (
    .clk(clk), .reset(rst[0]),
    .req0(req0[0]), .cmd0(cmd0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .req1(req1[0]), .cmd1(cmd1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata(rdata[0]), .busy(busy[0]), .mem_cmd(mem_cmd[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.AW(8), .DW(16), .RD_LAT(RL1), .CPU_PRIO(1)) u_pr (
    .clk(clk), .reset(rst[1]),
    .req0(req0[1]), .cmd0(cmd0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .req1(req1[1]), .cmd1(cmd1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata(rdata[1]), .busy(busy[1]), .mem_cmd(mem_cmd[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i);
    return (i == 5) ? 16'hABCD : {v, ~v};
  endfunction

  function automatic int rdl(input int k);
    return (k == 0) ? RL0 : RL1;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, req);
    end
  endfunction

  // RAM: writes commit on the edge, reads return after the instance's latency
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ram[k][i] = init_val(i);
      for (int j = 0; j < 3; j++) pipe[k][j] = 16'h0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mem_cmd[k] == MWRITE) ram[k][mem_addr[k]] <= mem_wdata[k];
        pipe[k][0] <= (mem_cmd[k] == MREAD) ? ram[k][mem_addr[k]] : 16'hDEAD;
        pipe[k][1] <= pipe[k][0];
        pipe[k][2] <= pipe[k][1];
      end
    end
  end
  assign mem_rdata[0] = pipe[0][RL0-1];
  assign mem_rdata[1] = pipe[1][RL1-1];

  // A synchronous reset abandons everything in flight and clears rdata
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst[k]) begin
        sb[2*k].delete();
        sb[2*k+1].delete();
        exp_last[k] = 16'h0;
      end
    end
  end

  task automatic mon(input int k);
    int   r, idx;
    exp_t e;
    logic [1:0] xc;
    if (gnt0[k] || gnt1[k]) begin
      chk($sformatf("d%0d_gnt_excl", k), 32'(gnt0[k] & gnt1[k]), 32'd0);
      r = gnt1[k] ? 1 : 0;
      idx = 2*k + r;
      gseq[k].push_back(r);
      chk($sformatf("d%0d_gnt%0d_pending", k, r), 32'(sb[idx].size() > 0), 32'd1);
      if (sb[idx].size() > 0) begin
        e = sb[idx][0];
        gcyc[idx] = cyc;
        xc = (e.cmd == MREAD || e.cmd == MWRITE) ? e.cmd : MNONE;
        chk($sformatf("d%0d_gnt%0d_mem_cmd", k, r), 32'(mem_cmd[k]), 32'(xc));
        if (xc != MNONE) chk($sformatf("d%0d_gnt%0d_mem_addr", k, r), 32'(mem_addr[k]), 32'(e.addr));
        if (xc == MWRITE) chk($sformatf("d%0d_gnt%0d_mem_wdata", k, r), 32'(mem_wdata[k]), 32'(e.wdata));
      end
    end
    if (done0[k] || done1[k]) begin
      chk($sformatf("d%0d_done_excl", k), 32'(done0[k] & done1[k]), 32'd0);
      r = done1[k] ? 1 : 0;
      idx = 2*k + r;
      chk($sformatf("d%0d_done%0d_pending", k, r), 32'(sb[idx].size() > 0), 32'd1);
      if (sb[idx].size() > 0) begin
        e = sb[idx].pop_front();
        chk($sformatf("d%0d_done%0d_latency", k, r), 32'(cyc - gcyc[idx]),
            32'((e.cmd == MREAD) ? 1 + rdl(k) : 1));
        chk($sformatf("d%0d_done%0d_mem_cmd", k, r), 32'(mem_cmd[k]), 32'(MNONE));
        if (e.cmd == MREAD) exp_last[k] = e.rdata;
        chk($sformatf("d%0d_done%0d_rdata", k, r), 32'(rdata[k]), 32'(exp_last[k]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic set_fields(input int k, input int r, input logic [1:0] c,
                            input logic [7:0] a, input logic [15:0] w);
    if (r == 0) begin cmd0[k] = c; addr0[k] = a; wdata0[k] = w; end
    else        begin cmd1[k] = c; addr1[k] = a; wdata1[k] = w; end
  endtask

  task automatic set_req(input int k, input int r, input logic v);
    if (r == 0) req0[k] = v;
    else        req1[k] = v;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("d%0d_%s_ctl", k, tag),
        32'({gnt0[k], gnt1[k], done0[k], done1[k], busy[k]}), 32'd0);
    chk($sformatf("d%0d_%s_mem_cmd", k, tag), 32'(mem_cmd[k]), 32'd0);
    chk($sformatf("d%0d_%s_mem_addr", k, tag), 32'(mem_addr[k]), 32'd0);
    chk($sformatf("d%0d_%s_mem_wdata", k, tag), 32'(mem_wdata[k]), 32'd0);
    chk($sformatf("d%0d_%s_rdata", k, tag), 32'(rdata[k]), 32'd0);
  endtask

  task automatic do_reset(input int k, input int ncyc);
    @(negedge clk);
    rst[k] = 1'b0;
    repeat (ncyc) @(negedge clk);
    chk_idle(k, "reset");
    rst[k] = 1'b1;
  endtask

  // One requester transaction; latencies are counted from the cycle req is first sampled
  task automatic do_txn(input int k, input int r, input logic [1:0] c, input logic [7:0] a,
                        input logic [15:0] w, output int glat, output int dlat);
    exp_t e;
    int   t0, n;
    e.cmd = c; e.addr = a; e.wdata = w; e.rdata = shadow[k][a];
    if (c == MWRITE) shadow[k][a] = w;
    @(negedge clk);
    set_fields(k, r, c, a, w);
    sb[2*k+r].push_back(e);
    set_req(k, r, 1'b1);
    t0 = cyc; glat = -1; dlat = -1; n = 0;
    while (glat < 0 && n < 1000) begin
      @(negedge clk); n++;
      if ((r == 0) ? gnt0[k] : gnt1[k]) glat = cyc - t0;
    end
    set_req(k, r, 1'b0);
    set_fields(k, r, 2'($urandom), 8'($urandom), 16'($urandom));
    n = 0;
    while (glat >= 0 && dlat < 0 && n < 100) begin
      @(negedge clk); n++;
      if ((r == 0) ? done0[k] : done1[k]) dlat = cyc - t0;
    end
    chk($sformatf("d%0d_r%0d_gnt_seen", k, r), 32'(glat >= 0), 32'd1);
    chk($sformatf("d%0d_r%0d_done_seen", k, r), 32'(dlat >= 0), 32'd1);
  endtask

  // Both requesters hold req high for reads; each drops on its n-th done
  task automatic hold_both(input int k, input int n0, input int n1,
                           input logic [7:0] a0, input logic [7:0] a1);
    exp_t e;
    int d0, d1, n;
    e.cmd = MREAD; e.wdata = 16'h0;
    e.addr = a0; e.rdata = shadow[k][a0];
    for (int i = 0; i < n0; i++) sb[2*k].push_back(e);
    e.addr = a1; e.rdata = shadow[k][a1];
    for (int i = 0; i < n1; i++) sb[2*k+1].push_back(e);
    @(negedge clk);
    set_fields(k, 0, MREAD, a0, 16'h0);
    set_fields(k, 1, MREAD, a1, 16'h0);
    req0[k] = (n0 > 0); req1[k] = (n1 > 0);
    d0 = 0; d1 = 0; n = 0;
    while ((d0 < n0 || d1 < n1) && n < 400) begin
      @(negedge clk); n++;
      if (done0[k]) begin d0++; if (d0 == n0) req0[k] = 1'b0; end
      if (done1[k]) begin d1++; if (d1 == n1) req1[k] = 1'b0; end
    end
    req0[k] = 1'b0; req1[k] = 1'b0;
    chk($sformatf("d%0d_hold_done0_count", k), 32'(d0), 32'(n0));
    chk($sformatf("d%0d_hold_done1_count", k), 32'(d1), 32'(n1));
  endtask

  task automatic check_order(input int k, input int exp_ord [4]);
    chk($sformatf("d%0d_grant_count", k), 32'(gseq[k].size()), 32'd4);
    for (int i = 0; i < 4 && i < gseq[k].size(); i++)
      chk($sformatf("d%0d_grant_order_%0d", k, i), 32'(gseq[k][i]), 32'(exp_ord[i]));
  endtask

  task automatic rand_drv(input int k, input int r, input int n);
    int gl, dl;
    logic [1:0] c;
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      c = 2'($urandom_range(0, 3));
      a = {1'(r), 4'b0000, 3'($urandom_range(0, 7))};
      do_txn(k, r, c, a, 16'($urandom), gl, dl);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    int gl, dl, cnt;
    int ord_rr [4] = '{0, 1, 0, 1};
    int ord_pr [4] = '{0, 0, 0, 1};
    rst = '0; req0 = '0; req1 = '0;
    cmd0 = '0; cmd1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_last[0] = 16'h0; exp_last[1] = 16'h0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) shadow[k][i] = init_val(i);

    // Reset held with a pending request: nothing may start
    req0[0] = 1'b1; cmd0[0] = MREAD; addr0[0] = 8'h05;
    fork
      do_reset(0, 2);
      do_reset(1, 2);
    join
    req0[0] = 1'b0;

    do_txn(0, 0, MREAD, 8'h05, 16'h0, gl, dl);
    chk("rd_first_gnt_lat", 32'(gl), 32'd1);
    chk("rd_first_done_lat", 32'(dl), 32'd3);
    chk("rd_first_rdata", 32'(rdata[0]), 32'h0000ABCD);

    do_txn(0, 1, MWRITE, 8'h10, 16'h1234, gl, dl);
    chk("wr_gnt_lat", 32'(gl), 32'd1);
    chk("wr_done_lat", 32'(dl), 32'd2);
    do_txn(0, 0, MREAD, 8'h10, 16'h0, gl, dl);
    chk("rd_after_wr_rdata", 32'(rdata[0]), 32'h00001234);

    do_reset(0, 1);
    gseq[0].delete();
    hold_both(0, 2, 2, 8'h20, 8'hA0);
    check_order(0, ord_rr);

    do_txn(0, 0, 2'b11, 8'h33, 16'hFFFF, gl, dl);
    chk("noop_gnt_lat", 32'(gl), 32'd1);
    chk("noop_done_lat", 32'(dl), 32'd2);
    chk("noop_rdata_kept", 32'(rdata[0]), 32'(shadow[0][8'hA0]));

    gseq[1].delete();
    hold_both(1, 3, 1, 8'h07, 8'h87);
    check_order(1, ord_pr);

    // Read abandoned by reset while waiting on the RAM
    begin
      exp_t e;
      e.cmd = MREAD; e.addr = 8'h07; e.wdata = 16'h0; e.rdata = shadow[1][8'h07];
      @(negedge clk);
      set_fields(1, 0, MREAD, 8'h07, 16'h0);
      sb[2].push_back(e);
      req0[1] = 1'b1;
      cnt = 0;
      while (!gnt0[1] && cnt < 20) begin @(negedge clk); cnt++; end
      chk("abort_gnt_seen", 32'(gnt0[1]), 32'd1);
      req0[1] = 1'b0;
      @(negedge clk);
      chk("abort_in_wait", 32'(busy[1]), 32'd1);
      rst[1] = 1'b0;
      @(negedge clk);
      chk_idle(1, "abort");
      rst[1] = 1'b1;
      cnt = 0;
      repeat (8) begin
        @(negedge clk);
        if (done0[1] || done1[1]) cnt++;
      end
      chk("abort_no_done", 32'(cnt), 32'd0);
    end
    do_txn(1, 0, MREAD, 8'h09, 16'h0, gl, dl);
    chk("rd_lat3_gnt_lat", 32'(gl), 32'd1);
    chk("rd_lat3_done_lat", 32'(dl), 32'd5);
    chk("rd_lat3_rdata", 32'(rdata[1]), 32'(init_val(9)));

    fork
      rand_drv(0, 0, 20);
      rand_drv(0, 1, 20);
      rand_drv(1, 0, 20);
      rand_drv(1, 1, 20);
    join
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++)
      chk($sformatf("sb%0d_drained", i), 32'(sb[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
